// File: rtl/bin_morph_pkg.sv
// rtl/bin_morph_pkg.sv - shared types and constants for the bin_compare frame sequencer
package bin_morph_pkg;

   localparam int THRESH_W = 4;
   localparam logic [THRESH_W-1:0] THRESH_MAX = 4'd9;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      CLOSE
   } bin_seq_state_e;

   typedef struct packed {
      logic [THRESH_W-1:0] thresh;
      logic                bypass;
   } cfg_t;

   // A 3x3 neighbourhood has at most 9 set pixels, so larger thresholds saturate.
   function automatic logic [THRESH_W-1:0] clamp_thresh(input logic [THRESH_W-1:0] t);
      return (t > THRESH_MAX) ? THRESH_MAX : t;
   endfunction

endpackage

// File: rtl/bin_morph_seq_if.sv
// rtl/bin_morph_seq_if.sv - configuration valid/ready bus for bin_morph_seq
interface bin_morph_seq_if;

   logic                               cfg_valid;
   logic                               cfg_ready;
   logic [bin_morph_pkg::THRESH_W-1:0] cfg_thresh;
   logic                               cfg_bypass;

   modport master (
      output cfg_valid,
      output cfg_thresh,
      output cfg_bypass,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_thresh,
      input  cfg_bypass,
      output cfg_ready
   );

endinterface

// File: rtl/bin_frame_mon.sv
// rtl/bin_frame_mon.sv - vsync/href edge detection, row/column counting and line-length checking
module bin_frame_mon
   import bin_morph_pkg::*;
#(
   parameter int IMG_HDISP = 450,
   parameter int IMG_VDISP = 280
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vsync,
   input  logic             in_href,
   input  logic             clr,
   input  logic             active,
   output logic             vs_rise,
   output logic             vs_fall,
   output logic             line_err,
   output logic             bad_frame,
   output logic [CNT_W-1:0] row_cnt
);

   localparam logic [CNT_W-1:0] COL_EXP = CNT_W'(IMG_HDISP);
   localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_HDISP + 1);
   localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_VDISP + 1);

   logic             vs_q, vs_d;
   logic             hr_q, hr_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic             line_err_q, line_err_d;
   logic             bad_q, bad_d;
   logic             hr_fall;

   assign vs_rise   = in_vsync & ~vs_q;
   assign vs_fall   = ~in_vsync & vs_q;
   assign hr_fall   = ~in_href & hr_q;
   assign line_err  = line_err_q;
   assign bad_frame = bad_q;
   assign row_cnt   = row_q;

   always_comb begin
      vs_d       = in_vsync;
      hr_d       = in_href;
      col_d      = col_q;
      row_d      = row_q;
      line_err_d = 1'b0;
      bad_d      = bad_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
         bad_d = 1'b0;
      end else if (active) begin
         if (in_href) begin
            if (col_q != COL_MAX) col_d = col_q + 1'b1;
         end else if (hr_fall) begin
            if (col_q != COL_EXP) begin
               line_err_d = 1'b1;
               bad_d      = 1'b1;
            end
            if (row_q != ROW_MAX) row_d = row_q + 1'b1;
            col_d = '0;
         end
      end
   end

   // vs_q resets high so a frame already running at reset release is not mistaken for a new one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q       <= 1'b1;
         hr_q       <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         line_err_q <= 1'b0;
         bad_q      <= 1'b0;
      end else begin
         vs_q       <= vs_d;
         hr_q       <= hr_d;
         col_q      <= col_d;
         row_q      <= row_d;
         line_err_q <= line_err_d;
         bad_q      <= bad_d;
      end
   end

endmodule

// File: rtl/bin_morph_seq.sv
// rtl/bin_morph_seq.sv - frame-synchronous threshold/bypass sequencer for one bin_compare stage
// Optional BIN_MORPH_STAT_EN adds err_cnt and last_rows statistics outputs.
module bin_morph_seq
   import bin_morph_pkg::*;
#(
   parameter int                  IMG_HDISP  = 450,
   parameter int                  IMG_VDISP  = 280,
   parameter logic [THRESH_W-1:0] THRESH_RST = 4'd6
) (
   input  logic                clk,
   input  logic                rst,
   bin_morph_seq_if.slave      cfg,
   input  logic                in_vsync,
   input  logic                in_href,
   output logic [THRESH_W-1:0] thresh,
   output logic                bypass,
   output logic                busy,
   output logic                frame_start,
   output logic                frame_done,
   output logic                line_err,
   output logic                frame_err,
   output logic [15:0]         frame_cnt
`ifdef BIN_MORPH_STAT_EN
   ,
   output logic [15:0]         err_cnt,
   output logic [15:0]         last_rows
`endif
);

   localparam logic [CNT_W-1:0] ROW_EXP = CNT_W'(IMG_VDISP);

   bin_seq_state_e   state_q, state_d;
   cfg_t             pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   cfg_t             cur_q, cur_d;
   logic             frame_start_q, frame_start_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;

   logic             vs_rise;
   logic             vs_fall;
   logic             bad_frame;
   logic [CNT_W-1:0] row_cnt;
   logic             start;

   assign start = (state_q == IDLE) && vs_rise;

   bin_frame_mon #(
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP)
   ) u_mon (
      .clk       (clk),
      .rst       (rst),
      .in_vsync  (in_vsync),
      .in_href   (in_href),
      .clr       (start),
      .active    (state_q == ACTIVE),
      .vs_rise   (vs_rise),
      .vs_fall   (vs_fall),
      .line_err  (line_err),
      .bad_frame (bad_frame),
      .row_cnt   (row_cnt)
   );

   assign cfg.cfg_ready = ~pend_valid_q;
   assign thresh        = cur_q.thresh;
   assign bypass        = cur_q.bypass;
   assign busy          = (state_q != IDLE);
   assign frame_start   = frame_start_q;
   assign frame_done    = (state_q == CLOSE);
   assign frame_err     = (state_q == CLOSE) && (bad_frame || (row_cnt != ROW_EXP));
   assign frame_cnt     = frame_cnt_q;

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      pend_valid_d  = pend_valid_q;
      cur_d         = cur_q;
      frame_start_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;

      // Capture uses the old pend_valid_q, so a transfer landing on the vsync rise waits a frame.
      if (cfg.cfg_valid && !pend_valid_q) begin
         pend_d.thresh = clamp_thresh(cfg.cfg_thresh);
         pend_d.bypass = cfg.cfg_bypass;
         pend_valid_d  = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (vs_rise) begin
               state_d       = ACTIVE;
               frame_start_d = 1'b1;
               if (pend_valid_q) begin
                  cur_d        = pend_q;
                  pend_valid_d = 1'b0;
               end
            end
         end
         ACTIVE: begin
            if (vs_fall) state_d = CLOSE;
         end
         CLOSE: begin
            state_d     = IDLE;
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pend_q        <= '{thresh: '0, bypass: 1'b0};
         pend_valid_q  <= 1'b0;
         cur_q         <= '{thresh: THRESH_RST, bypass: 1'b0};
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         pend_valid_q  <= pend_valid_d;
         cur_q         <= cur_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

`ifdef BIN_MORPH_STAT_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [15:0] last_rows_q, last_rows_d;

   assign err_cnt   = err_cnt_q;
   assign last_rows = last_rows_q;

   always_comb begin
      err_cnt_d   = err_cnt_q;
      last_rows_d = last_rows_q;
      if (state_q == CLOSE) begin
         err_cnt_d   = err_cnt_q + {15'd0, frame_err};
         last_rows_d = 16'(row_cnt);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q   <= '0;
         last_rows_q <= '0;
      end else begin
         err_cnt_q   <= err_cnt_d;
         last_rows_q <= last_rows_d;
      end
   end
`endif

endmodule

// File: tb/tb_bin_morph_seq.sv
// tb/tb_bin_morph_seq.sv - directed self-checking bench for bin_morph_seq with a per-frame scoreboard
module tb_bin_morph_seq;

   localparam int HD = 20;
   localparam int VD = 14;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vsync;
   logic        in_href;
   logic [3:0]  thresh;
   logic        bypass;
   logic        busy;
   logic        frame_start;
   logic        frame_done;
   logic        line_err;
   logic        frame_err;
   logic [15:0] frame_cnt;
`ifdef BIN_MORPH_STAT_EN
   logic [15:0] err_cnt;
   logic [15:0] last_rows;
`endif

   bin_morph_seq_if cfg_bus ();

   bin_morph_seq #(
      .IMG_HDISP  (HD),
      .IMG_VDISP  (VD),
      .THRESH_RST (4'd6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg         (cfg_bus),
      .in_vsync    (in_vsync),
      .in_href     (in_href),
      .thresh      (thresh),
      .bypass      (bypass),
      .busy        (busy),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .line_err    (line_err),
      .frame_err   (frame_err),
      .frame_cnt   (frame_cnt)
`ifdef BIN_MORPH_STAT_EN
      ,
      .err_cnt     (err_cnt),
      .last_rows   (last_rows)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] thresh;
      logic       bypass;
      logic       err;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [3:0]  m_thresh;
   logic        m_bypass;
   logic [3:0]  m_pend_thresh;
   logic        m_pend_bypass;
   logic        m_pend_valid;
   logic [15:0] m_fcnt;
   logic [15:0] m_ecnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] clamp9(input logic [3:0] t);
      return (t > 4'd9) ? 4'd9 : t;
   endfunction

   task automatic model_reset();
      m_thresh     = 4'd6;
      m_bypass     = 1'b0;
      m_pend_valid = 1'b0;
      m_fcnt       = '0;
      m_ecnt       = '0;
      sb.delete();
   endtask

   task automatic send_cfg(input logic [3:0] th, input logic bp);
      check("cfg_ready_before", cfg_bus.cfg_ready, 1);
      cfg_bus.cfg_valid  = 1'b1;
      cfg_bus.cfg_thresh = th;
      cfg_bus.cfg_bypass = bp;
      tick();
      cfg_bus.cfg_valid = 1'b0;
      m_pend_thresh = clamp9(th);
      m_pend_bypass = bp;
      m_pend_valid  = 1'b1;
      check("cfg_ready_after", cfg_bus.cfg_ready, 0);
   endtask

   task automatic run_frame(input int nlines, input int short_line, input bit cfg_at_rise,
                            input logic [3:0] cth, input logic cbp);
      exp_t e;
      exp_t got;
      bit   was_pend;
      int   len;
      e.err = ((short_line >= 0) && (short_line < nlines)) || (nlines != VD);

      in_vsync = 1'b1;
      if (cfg_at_rise) begin
         cfg_bus.cfg_valid  = 1'b1;
         cfg_bus.cfg_thresh = cth;
         cfg_bus.cfg_bypass = cbp;
      end
      tick();
      cfg_bus.cfg_valid = 1'b0;

      was_pend = m_pend_valid;
      if (was_pend) begin
         m_thresh     = m_pend_thresh;
         m_bypass     = m_pend_bypass;
         m_pend_valid = 1'b0;
      end
      if (cfg_at_rise && !was_pend) begin
         m_pend_thresh = clamp9(cth);
         m_pend_bypass = cbp;
         m_pend_valid  = 1'b1;
      end
      e.thresh = m_thresh;
      e.bypass = m_bypass;
      sb.push_back(e);

      check("frame_start_pulse", frame_start, 1);
      check("thresh_at_rise", thresh, m_thresh);
      check("bypass_at_rise", bypass, m_bypass);
      check("cfg_ready_at_rise", cfg_bus.cfg_ready, !m_pend_valid);
      check("busy_active", busy, 1);
      tick();
      check("frame_start_one_cycle", frame_start, 0);
      tick();

      for (int l = 0; l < nlines; l++) begin
         len = (l == short_line) ? HD - 1 : HD;
         in_href = 1'b1;
         repeat (len) tick();
         in_href = 1'b0;
         tick();
         check($sformatf("line_err_l%0d", l), line_err, (len != HD));
         tick();
      end

      in_vsync = 1'b0;
      tick();
      check("frame_done_pulse", frame_done, 1);
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
         got = sb.pop_front();
         check("frame_err", frame_err, got.err);
         check("thresh_in_frame", thresh, got.thresh);
         check("bypass_in_frame", bypass, got.bypass);
         m_fcnt = m_fcnt + 16'd1;
         if (got.err) m_ecnt = m_ecnt + 16'd1;
      end
      tick();
      check("frame_done_one_cycle", frame_done, 0);
      check("busy_idle", busy, 0);
      check("frame_cnt", frame_cnt, m_fcnt);
`ifdef BIN_MORPH_STAT_EN
      check("err_cnt", err_cnt, m_ecnt);
      check("last_rows", last_rows, nlines);
`endif
      tick();
   endtask

   initial begin
      bit seen;

      rst                = 1'b1;
      in_vsync           = 1'b1;
      in_href            = 1'b0;
      cfg_bus.cfg_valid  = 1'b0;
      cfg_bus.cfg_thresh = 4'd0;
      cfg_bus.cfg_bypass = 1'b0;
      model_reset();
      tick();
      tick();
      check("rst_cfg_ready", cfg_bus.cfg_ready, 1);
      check("rst_thresh", thresh, 6);
      check("rst_bypass", bypass, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);

      // Release reset inside a frame that is already running.
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         in_href = ((i % 10) < 5);
         tick();
         if (frame_start || busy) seen = 1'b1;
      end
      in_href = 1'b0;
      check("no_start_midframe", seen, 0);
      check("thresh_idle", thresh, 6);
      in_vsync = 1'b0;
      seen     = 1'b0;
      repeat (3) begin
         tick();
         if (frame_done) seen = 1'b1;
      end
      check("no_done_midframe", seen, 0);

      send_cfg(4'd3, 1'b0);
      run_frame(VD, -1, 1'b0, 4'd0, 1'b0);

      run_frame(VD, -1, 1'b1, 4'd5, 1'b1);
      run_frame(VD, -1, 1'b0, 4'd0, 1'b0);

      run_frame(VD, 10, 1'b0, 4'd0, 1'b0);

      send_cfg(4'd12, 1'b0);
      run_frame(VD - 1, -1, 1'b0, 4'd0, 1'b0);

      // Abort a frame with reset while a new configuration is pending.
      in_vsync = 1'b1;
      tick();
      check("abort_frame_start", frame_start, 1);
      tick();
      tick();
      in_href = 1'b1;
      repeat (HD) tick();
      in_href = 1'b0;
      tick();
      send_cfg(4'd7, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_thresh", thresh, 6);
      check("async_rst_busy", busy, 0);
      tick();
      check("midrst_thresh", thresh, 6);
      check("midrst_bypass", bypass, 0);
      check("midrst_busy", busy, 0);
      check("midrst_frame_start", frame_start, 0);
      check("midrst_frame_done", frame_done, 0);
      check("midrst_line_err", line_err, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_cfg_ready", cfg_bus.cfg_ready, 1);
`ifdef BIN_MORPH_STAT_EN
      check("midrst_err_cnt", err_cnt, 0);
      check("midrst_last_rows", last_rows, 0);
`endif
      rst = 1'b0;
      model_reset();
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         in_href  = ((i % 8) < 4) && (i < 20);
         in_vsync = (i < 24);
         tick();
         if (frame_done || frame_start) seen = 1'b1;
      end
      in_href = 1'b0;
      check("no_done_aborted", seen, 0);

      run_frame(VD, -1, 1'b0, 4'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
